// File: rtl/uart_tx_fifo_if.sv
// Byte-producer to UART transmitter bundle: write strobe, data, FIFO status, line.
// master = producer side, slave = uart_tx_fifo side.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 i_wr;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_full;
    logic                 o_empty;
    logic [CW-1:0]        o_count;
    logic                 o_busy;
    logic                 o_uart_tx;

    modport master (
        output i_wr, i_data,
        input  o_full, o_empty, o_count, o_busy, o_uart_tx
    );

    modport slave (
        input  i_wr, i_data,
        output o_full, o_empty, o_count, o_busy, o_uart_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with baud generator and write FIFO; configurable frame format.
// Ports: i_clk, i_reset (async, active high), bus (uart_tx_fifo_if.slave):
//   i_wr/i_data enqueue, o_full/o_empty/o_count status, o_busy, o_uart_tx line.
// Optional parity bit after the payload when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLOCK_HZ   = 16_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input logic          i_clk,
    input logic          i_reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV      = (CLOCK_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int BW       = $clog2(STOP_LEN);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: bit period below 2 clocks");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    logic [2:0]           state_q;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] sh_q;
    logic                 tx_q;
    logic                 baud_end;
    logic                 stop_end;
    logic                 last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    assign head     = mem[rd_ptr];
    assign baud_end = (baud_cnt == BW'(DIV - 1));
    assign stop_end = (baud_cnt == BW'(STOP_LEN - 1));
    assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));

    // Full is checked before any pop, so a write while full is always dropped.
    assign push = bus.i_wr && !full_q;
    assign pop  = !empty_q &&
                  ((state_q == S_IDLE) || (state_q == S_STOP && stop_end));

    assign count_nxt = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(FIFO_DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q  <= S_START;
                        baud_cnt <= '0;
                        sh_q     <= head;
                        tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_q    <= (^head) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        state_q  <= S_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= sh_q[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sh_q    <= sh_q >> 1;
                            tx_q    <= sh_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        state_q  <= S_STOP;
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (stop_end) begin
                        baud_cnt <= '0;
                        // Back-to-back frames: next start follows with no idle gap.
                        if (pop) begin
                            state_q <= S_START;
                            sh_q    <= head;
                            tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            par_q   <= (^head) ^ (PARITY_ODD != 0);
`endif
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_full    = full_q;
    assign bus.o_empty   = empty_q;
    assign bus.o_count   = count_q;
    assign bus.o_busy    = (state_q != S_IDLE) || !empty_q;
    assign bus.o_uart_tx = tx_q;
endmodule
